// File: rtl/nmcu_pkg.sv
// Shared types and constants for the NMCU side of the controller<->NMCU bus.
// Descriptor word layout: type[1:0], w[5:2], h[9:6], ks[12:10], kaddr[31:16].
package nmcu_pkg;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    READ_DESCS   = 4'd1,
    READ_KERNELS = 4'd2,
    READ_INPUTS  = 4'd3,
    WRITE        = 4'd4,
    FINISHED     = 4'd5
  } state_t;

  typedef enum logic [1:0] {
    WB_WAIT_LOW = 2'd0,
    WB_REQ      = 2'd1,
    WB_DROP     = 2'd2
  } wb_state_t;

  localparam logic [1:0] NOP_TYPE  = 2'd0;
  localparam logic [1:0] CONV_TYPE = 2'd1;
  localparam logic [1:0] POOL_TYPE = 2'd2;
  localparam logic [1:0] RELU_TYPE = 2'd3;

  localparam logic [1:0] CAP_DESC   = 2'd0;
  localparam logic [1:0] CAP_KERNEL = 2'd1;
  localparam logic [1:0] CAP_INPUT  = 2'd2;

  function automatic logic [1:0] desc_type(input logic [31:0] d);
    return d[1:0];
  endfunction

  function automatic logic [3:0] desc_w(input logic [31:0] d);
    return d[5:2];
  endfunction

  function automatic logic [3:0] desc_h(input logic [31:0] d);
    return d[9:6];
  endfunction

  function automatic logic [2:0] desc_ks(input logic [31:0] d);
    return d[12:10];
  endfunction

  function automatic logic [15:0] desc_kaddr(input logic [31:0] d);
    return d[31:16];
  endfunction

endpackage

// File: rtl/nmcu_wb_req.sv
// Writeback request engine: takes one result from the core, raises a bus write
// request carrying it, and drives the shared data bus only while requesting.
module nmcu_wb_req
  import nmcu_pkg::*;
#(
  parameter int DATABUS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_mem_ready,
  input  logic                     i_res_valid,
  input  logic [DATABUS_WIDTH-1:0] i_res_data,
  input  logic                     i_res_last,
  output logic                     o_res_ready,
  output logic                     o_mem_sel,
  output logic                     o_mem_w,
  output logic                     o_wr_done,
  output logic                     o_wr_last,
  output wb_state_t                o_state,
  inout  wire  [DATABUS_WIDTH-1:0] io_data_bus
);

  // Result handshake: a result moves from the core when res_valid and
  // res_ready are both high at a posedge. res_data is captured on the edge
  // that raises res_ready, so the core must hold res_data stable while
  // res_valid is asserted (the usual rule for a valid/ready source).
  wb_state_t                r_state;
  logic                     r_res_ready;
  logic                     r_sel;
  logic                     r_last;
  logic [DATABUS_WIDTH-1:0] r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= WB_WAIT_LOW;
      r_res_ready <= 1'b0;
      r_sel       <= 1'b0;
      r_last      <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_res_ready <= 1'b0;
      if (!i_en) begin
        r_state <= WB_WAIT_LOW;
        r_sel   <= 1'b0;
      end else begin
        case (r_state)
          WB_WAIT_LOW: begin
            // mem_ready must be seen low first so a sticky flag is never
            // mistaken for an acknowledge.
            if (!i_mem_ready && i_res_valid) begin
              r_res_ready <= 1'b1;
              r_wdata     <= i_res_data;
              r_last      <= i_res_last;
              r_sel       <= 1'b1;
              r_state     <= WB_REQ;
            end
          end
          WB_REQ: begin
            if (i_mem_ready) begin
              r_sel   <= 1'b0;
              r_state <= WB_DROP;
            end
          end
          WB_DROP: begin
            if (!i_mem_ready) r_state <= WB_WAIT_LOW;
          end
          default: r_state <= WB_WAIT_LOW;
        endcase
      end
    end
  end

  assign o_res_ready = r_res_ready;
  assign o_mem_sel   = r_sel;
  assign o_mem_w     = r_sel;
  assign o_wr_done   = i_en && (r_state == WB_REQ) && i_mem_ready;
  assign o_wr_last   = r_last;
  assign o_state     = r_state;
  assign io_data_bus = r_sel ? r_wdata : 'z;

endmodule

// File: rtl/nmcu_bus_agent.sv
// NMCU bus endpoint: phase FSM, transfer detection on controller broadcasts,
// capture strobes to the compute core, and writeback via nmcu_wb_req.
module nmcu_bus_agent
  import nmcu_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATABUS_WIDTH = 32,
  parameter int MAX_DESCS     = 8,
  parameter int MAX_INPUT_DIM = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [$clog2(MAX_INPUT_DIM):0]      full_input_width,
  input  logic [$clog2(MAX_INPUT_DIM):0]      full_input_height,
  output logic [3:0]                          state,
  output logic                                mem_sel,
  output logic                                mem_w,
  input  logic                                mem_ready,
  input  logic [ADDR_WIDTH-1:0]               addr_bus,
  inout  wire  [DATABUS_WIDTH-1:0]            data_bus,
  output logic                                cap_valid,
  output logic [1:0]                          cap_kind,
  output logic [$clog2(MAX_DESCS)-1:0]        cap_layer,
  output logic [2*$clog2(MAX_INPUT_DIM)-1:0]  cap_index,
  output logic [DATABUS_WIDTH-1:0]            cap_data,
  input  logic                                res_valid,
  input  logic [DATABUS_WIDTH-1:0]            res_data,
  input  logic                                res_last,
  output logic                                res_ready,
  output logic                                done,
  output logic [1:0]                          wb_state
);

  localparam int LW = $clog2(MAX_DESCS);
  localparam int NW = LW + 1;
  localparam int IW = 2 * $clog2(MAX_INPUT_DIM);

  state_t                   r_state;
  logic [DATABUS_WIDTH-1:0] r_desc [MAX_DESCS];
  logic [NW-1:0]            r_n_layers;
  logic [NW-1:0]            r_layer;
  logic [IW-1:0]            r_idx;
  logic [IW:0]              r_total;
  logic                     r_first;
  logic [ADDR_WIDTH-1:0]    r_last_addr;
  logic                     r_done;
  logic                     r_cap_valid;
  logic [1:0]               r_cap_kind;
  logic [LW-1:0]            r_cap_layer;
  logic [IW-1:0]            r_cap_index;
  logic [DATABUS_WIDTH-1:0] r_cap_data;

  logic [DATABUS_WIDTH-1:0] w_cur_desc;
  logic [2:0]               w_ks;
  logic [IW:0]              w_ks_sq;
  logic                     w_kern_conv;
  logic                     w_layers_done;
  logic                     w_kern_last;
  logic                     w_in_last;
  logic                     w_xfer;
  logic                     w_take;
  logic [1:0]               w_kind;
  logic [LW-1:0]            w_layer;
  logic                     w_wr_done;
  logic                     w_wr_last;
  wb_state_t                w_wb_state;

  assign w_cur_desc    = r_desc[r_layer[LW-1:0]];
  assign w_ks          = desc_ks(w_cur_desc);
  assign w_ks_sq       = (IW+1)'(w_ks) * (IW+1)'(w_ks);
  assign w_kern_conv   = (desc_type(w_cur_desc) == CONV_TYPE) && (w_ks != 3'd0);
  assign w_layers_done = (r_layer == r_n_layers);
  assign w_kern_last   = ({1'b0, r_idx} == w_ks_sq - (IW+1)'(1));
  assign w_in_last     = ({1'b0, r_idx} == r_total - (IW+1)'(1));
  // A held mem_ready with an unchanged address is the same word, not a new one.
  assign w_xfer        = mem_ready && (r_first || (addr_bus != r_last_addr));

  always_comb begin
    w_take  = 1'b0;
    w_kind  = CAP_DESC;
    w_layer = '0;
    case (r_state)
      READ_DESCS: begin
        w_take  = w_xfer;
        w_layer = r_layer[LW-1:0];
      end
      READ_KERNELS: begin
        w_take  = w_xfer && !w_layers_done && w_kern_conv;
        w_kind  = CAP_KERNEL;
        w_layer = r_layer[LW-1:0];
      end
      READ_INPUTS: begin
        w_take = w_xfer;
        w_kind = CAP_INPUT;
      end
      default: w_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      for (int i = 0; i < MAX_DESCS; i++) r_desc[i] <= '0;
      r_n_layers  <= '0;
      r_layer     <= '0;
      r_idx       <= '0;
      r_total     <= '0;
      r_first     <= 1'b0;
      r_last_addr <= '0;
      r_done      <= 1'b0;
      r_cap_valid <= 1'b0;
      r_cap_kind  <= '0;
      r_cap_layer <= '0;
      r_cap_index <= '0;
      r_cap_data  <= '0;
    end else begin
      r_cap_valid <= w_take;
      if (w_take) begin
        r_cap_data  <= data_bus;
        r_cap_kind  <= w_kind;
        r_cap_layer <= w_layer;
        r_cap_index <= (r_state == READ_DESCS) ? '0 : r_idx;
        r_last_addr <= addr_bus;
        r_first     <= 1'b0;
      end
      case (r_state)
        IDLE, FINISHED: begin
          if (start) begin
            r_state <= READ_DESCS;
            r_layer <= '0;
            r_idx   <= '0;
            r_first <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        READ_DESCS: begin
          if (w_take) begin
            r_desc[r_layer[LW-1:0]] <= data_bus;
            if (desc_type(data_bus) == NOP_TYPE) begin
              r_n_layers <= r_layer;
              r_layer    <= '0;
              r_first    <= 1'b1;
              r_state    <= READ_KERNELS;
            end else if (r_layer == NW'(MAX_DESCS - 1)) begin
              r_n_layers <= NW'(MAX_DESCS);
              r_layer    <= '0;
              r_first    <= 1'b1;
              r_state    <= READ_KERNELS;
            end else begin
              r_layer <= r_layer + NW'(1);
            end
          end
        end
        READ_KERNELS: begin
          if (w_layers_done) begin
            // Input geometry is frozen here for the whole input phase.
            r_total <= (IW+1)'(full_input_width) * (IW+1)'(full_input_height);
            r_idx   <= '0;
            r_first <= 1'b1;
            r_state <= READ_INPUTS;
          end else if (!w_kern_conv) begin
            r_layer <= r_layer + NW'(1);
            r_idx   <= '0;
          end else if (w_take) begin
            if (w_kern_last) begin
              r_idx   <= '0;
              r_layer <= r_layer + NW'(1);
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        READ_INPUTS: begin
          if (w_take) begin
            if (w_in_last) begin
              r_idx   <= '0;
              r_state <= WRITE;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        WRITE: begin
          if (w_wr_done && w_wr_last) begin
            r_done  <= 1'b1;
            r_state <= FINISHED;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  nmcu_wb_req #(
    .DATABUS_WIDTH(DATABUS_WIDTH)
  ) u_wb_req (
    .clk         (clk),
    .rst         (rst),
    .i_en        (r_state == WRITE),
    .i_mem_ready (mem_ready),
    .i_res_valid (res_valid),
    .i_res_data  (res_data),
    .i_res_last  (res_last),
    .o_res_ready (res_ready),
    .o_mem_sel   (mem_sel),
    .o_mem_w     (mem_w),
    .o_wr_done   (w_wr_done),
    .o_wr_last   (w_wr_last),
    .o_state     (w_wb_state),
    .io_data_bus (data_bus)
  );

  assign state     = r_state;
  assign done      = r_done;
  assign cap_valid = r_cap_valid;
  assign cap_kind  = r_cap_kind;
  assign cap_layer = r_cap_layer;
  assign cap_index = r_cap_index;
  assign cap_data  = r_cap_data;
  assign wb_state  = w_wb_state;

endmodule

// File: tb/tb_nmcu_bus_agent.sv
// Directed bench for nmcu_bus_agent: descriptor, kernel, input and writeback
// phases, async reset mid-run, restart from FINISHED.
module tb_nmcu_bus_agent;
  import nmcu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  full_input_width = 5'd4;
  logic [4:0]  full_input_height = 5'd3;
  logic [3:0]  state;
  logic        mem_sel, mem_w;
  logic        mem_ready = 1'b0;
  logic [15:0] addr_bus = '0;
  wire  [31:0] data_bus;
  logic        cap_valid;
  logic [1:0]  cap_kind;
  logic [2:0]  cap_layer;
  logic [7:0]  cap_index;
  logic [31:0] cap_data;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic        res_last = 1'b0;
  logic        res_ready;
  logic        done;
  logic [1:0]  wb_state;

  logic        tb_drv = 1'b1;
  logic [31:0] tb_data = 32'hDEAD_BEEF;
  assign data_bus = tb_drv ? tb_data : 'z;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  nmcu_bus_agent dut (
    .clk(clk), .rst(rst), .start(start),
    .full_input_width(full_input_width), .full_input_height(full_input_height),
    .state(state), .mem_sel(mem_sel), .mem_w(mem_w), .mem_ready(mem_ready),
    .addr_bus(addr_bus), .data_bus(data_bus),
    .cap_valid(cap_valid), .cap_kind(cap_kind), .cap_layer(cap_layer),
    .cap_index(cap_index), .cap_data(cap_data),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
    .res_ready(res_ready), .done(done), .wb_state(wb_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [15:0] a, input logic [31:0] d);
    addr_bus  = a;
    tb_data   = d;
    mem_ready = 1'b1;
    tick();
  endtask

  task automatic chk_cap(input string tag, input logic [1:0] kind, input logic [2:0] layer,
                         input logic [7:0] index);
    logic [31:0] exp_data;
    exp_data = exp_q.pop_front();
    chk({tag, "_valid"}, 64'(cap_valid), 64'(1'b1));
    chk({tag, "_kind"},  64'(cap_kind),  64'(kind));
    chk({tag, "_layer"}, 64'(cap_layer), 64'(layer));
    chk({tag, "_index"}, 64'(cap_index), 64'(index));
    chk({tag, "_data"},  64'(cap_data),  64'(exp_data));
  endtask

  initial begin
    // reset values
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_state", 64'(state), 64'(IDLE));
    chk("rst_mem_sel", 64'(mem_sel), 64'(0));
    chk("rst_mem_w", 64'(mem_w), 64'(0));
    chk("rst_cap_valid", 64'(cap_valid), 64'(0));
    chk("rst_cap_data", 64'(cap_data), 64'(0));
    chk("rst_res_ready", 64'(res_ready), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_bus_free", 64'(data_bus), 64'(32'hDEAD_BEEF));

    // run 1: CONV ks=1 then NOP -> one layer
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r1_state_descs", 64'(state), 64'(READ_DESCS));
    exp_q.push_back(32'h0040_0405);
    present(16'h0010, 32'h0040_0405);
    chk_cap("r1_desc0", CAP_DESC, 3'd0, 8'd0);
    chk("r1_state_still_descs", 64'(state), 64'(READ_DESCS));
    exp_q.push_back(32'h0000_0000);
    present(16'h0011, 32'h0000_0000);
    chk_cap("r1_desc1", CAP_DESC, 3'd1, 8'd0);
    chk("r1_state_kernels", 64'(state), 64'(READ_KERNELS));
    mem_ready = 1'b0;

    // async reset mid-READ_KERNELS, visible before the next edge
    rst = 1'b1;
    #1;
    chk("mid_rst_state", 64'(state), 64'(IDLE));
    chk("mid_rst_cap_valid", 64'(cap_valid), 64'(0));
    chk("mid_rst_cap_data", 64'(cap_data), 64'(0));
    chk("mid_rst_mem_sel", 64'(mem_sel), 64'(0));
    chk("mid_rst_bus_free", 64'(data_bus), 64'(tb_data));
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_state", 64'(state), 64'(IDLE));

    // run 2: POOL, CONV ks=2, CONV ks=3, NOP
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(32'h0000_0002);
    present(16'h0010, 32'h0000_0002);
    chk_cap("r2_desc0", CAP_DESC, 3'd0, 8'd0);
    exp_q.push_back(32'h0000_0801);
    present(16'h0011, 32'h0000_0801);
    chk_cap("r2_desc1", CAP_DESC, 3'd1, 8'd0);
    exp_q.push_back(32'h0000_0C01);
    present(16'h0012, 32'h0000_0C01);
    chk_cap("r2_desc2", CAP_DESC, 3'd2, 8'd0);
    exp_q.push_back(32'h0000_0000);
    present(16'h0013, 32'h0000_0000);
    chk_cap("r2_desc3", CAP_DESC, 3'd3, 8'd0);
    chk("r2_state_kernels", 64'(state), 64'(READ_KERNELS));

    // POOL layer 0 skipped in one cycle
    mem_ready = 1'b0;
    tick();
    chk("skip_no_cap", 64'(cap_valid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0000_0100 + 32'(i));
      present(16'h0030 + 16'(i), 32'h0000_0100 + 32'(i));
      chk_cap("k2", CAP_KERNEL, 3'd1, 8'(i));
    end
    // ks=3: nine words, each followed by an address-hold cycle
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(32'h0000_0200 + 32'(i));
      present(16'h0040 + 16'(i), 32'h0000_0200 + 32'(i));
      chk_cap("k3", CAP_KERNEL, 3'd2, 8'(i));
      tick();
      chk("k3_hold_no_cap", 64'(cap_valid), 64'(0));
    end
    mem_ready = 1'b0;
    chk("state_inputs", 64'(state), 64'(READ_INPUTS));

    // inputs 4x3, width poked mid-phase, start while busy
    for (int i = 0; i < 12; i++) exp_q.push_back(32'h0000_1000 + 32'(i));
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        full_input_width = 5'd7;
        start = 1'b1;
      end
      present(16'h0100 + 16'(i), 32'h0000_1000 + 32'(i));
      start = 1'b0;
      chk_cap("in", CAP_INPUT, 3'd0, 8'(i));
      if (i < 11) chk("in_state", 64'(state), 64'(READ_INPUTS));
    end
    chk("state_write", 64'(state), 64'(WRITE));

    // writeback: mem_ready still high on entry, no request until it drops
    tb_drv    = 1'b0;
    res_valid = 1'b1;
    res_data  = 32'h0000_00A5;
    res_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wb_stuck_sel", 64'(mem_sel), 64'(0));
      chk("wb_stuck_ready", 64'(res_ready), 64'(0));
    end
    mem_ready = 1'b0;
    tick();
    chk("wb1_res_ready", 64'(res_ready), 64'(1));
    chk("wb1_sel", 64'(mem_sel), 64'(1));
    chk("wb1_w", 64'(mem_w), 64'(1));
    chk("wb1_data", 64'(data_bus), 64'(32'h0000_00A5));
    tick();
    chk("wb1_ready_pulse", 64'(res_ready), 64'(0));
    chk("wb1_sel_held", 64'(mem_sel), 64'(1));
    res_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
    chk("wb1_dropped", 64'(mem_sel), 64'(0));
    chk("wb1_state", 64'(state), 64'(WRITE));
    res_valid = 1'b1;
    res_data  = 32'h0000_005A;
    res_last  = 1'b1;
    tick();
    chk("wb2_wait_low_sel", 64'(mem_sel), 64'(0));
    chk("wb2_wait_low_ready", 64'(res_ready), 64'(0));
    mem_ready = 1'b0;
    tick();
    chk("wb2_rearm_sel", 64'(mem_sel), 64'(0));
    tick();
    chk("wb2_res_ready", 64'(res_ready), 64'(1));
    chk("wb2_sel", 64'(mem_sel), 64'(1));
    chk("wb2_data", 64'(data_bus), 64'(32'h0000_005A));
    tick();
    res_valid = 1'b0;
    res_last  = 1'b0;
    mem_ready = 1'b1;
    tick();
    chk("fin_state", 64'(state), 64'(FINISHED));
    chk("fin_done", 64'(done), 64'(1));
    chk("fin_sel", 64'(mem_sel), 64'(0));
    mem_ready = 1'b0;
    tick();
    chk("fin_hold", 64'(state), 64'(FINISHED));

    // restart from FINISHED
    tb_drv = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("restart_state", 64'(state), 64'(READ_DESCS));
    chk("restart_done", 64'(done), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
